// File: rtl/robo_atuador_if.sv
// Command strobes from the navigation FSM and the drive/status outputs toward the power stage.
// master drives the strobes; slave (the sequencer) drives the outputs.
interface robo_atuador_if;
    logic       avancar;
    logic       girar;
    logic       recolher_entulho;
    logic       motor_esq;
    logic       motor_dir;
    logic       sentido_esq;
    logic       garra;
    logic       busy;
    logic       done;
    logic       conflito;
    logic [7:0] perdidos;

    modport master (
        output avancar, girar, recolher_entulho,
        input  motor_esq, motor_dir, sentido_esq, garra, busy, done, conflito, perdidos
    );

    modport slave (
        input  avancar, girar, recolher_entulho,
        output motor_esq, motor_dir, sentido_esq, garra, busy, done, conflito, perdidos
    );
endinterface

// File: rtl/robo_atuador.sv
// Actuator sequencer: turns one-cycle nav strobes into timed wheel/claw windows (soft start: ROBO_ATUADOR_RAMPA_EN).
// Latency: drive window starts the cycle after the strobe edge, lasts T_x cycles, then one done cycle.
// No backpressure: strobes arriving while busy are dropped and counted in perdidos.
module robo_atuador #(
    parameter int unsigned T_AVANCO  = 8,
    parameter int unsigned T_GIRO    = 4,
    parameter int unsigned T_ENTULHO = 6
) (
    input  logic           clock,
    input  logic           reset,
    robo_atuador_if.slave  io
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        AVANCO  = 3'd1,
        GIRO    = 3'd2,
        RECOLHE = 3'd3,
        FIM     = 3'd4
    } state_t;

    localparam logic [7:0] LOAD_AVANCO  = 8'(T_AVANCO - 1);
    localparam logic [7:0] LOAD_GIRO    = 8'(T_GIRO - 1);
    localparam logic [7:0] LOAD_ENTULHO = 8'(T_ENTULHO - 1);

`ifdef ROBO_ATUADOR_RAMPA_EN
    // cnt value during the second AVANCO cycle, the one whose wheel pulse is suppressed
    localparam bit         RAMPA_GAP_EN = (T_AVANCO >= 2);
    localparam logic [7:0] RAMPA_GAP    = 8'(T_AVANCO - 2);
`endif

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [7:0] perdidos_n;
    logic       conflito_n;
    logic       any_stb, multi_stb;
    logic       rodas_n, sentido_n, garra_n, busy_n, done_n;

    assign any_stb   = io.avancar | io.girar | io.recolher_entulho;
    assign multi_stb = (io.avancar & io.girar) | (io.avancar & io.recolher_entulho)
                     | (io.girar & io.recolher_entulho);

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        perdidos_n = io.perdidos;
        conflito_n = io.conflito;
        unique case (state)
            IDLE, FIM: begin
                state_n = IDLE;
                if (io.recolher_entulho) begin
                    state_n = RECOLHE;
                    cnt_n   = LOAD_ENTULHO;
                end else if (io.girar) begin
                    state_n = GIRO;
                    cnt_n   = LOAD_GIRO;
                end else if (io.avancar) begin
                    state_n = AVANCO;
                    cnt_n   = LOAD_AVANCO;
                end
                if (multi_stb) conflito_n = 1'b1;
            end
            AVANCO, GIRO, RECOLHE: begin
                if (any_stb && io.perdidos != 8'hFF) perdidos_n = io.perdidos + 8'd1;
                if (cnt == 8'd0) state_n = FIM;
                else             cnt_n   = cnt - 8'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they come straight out of flops.
    always_comb begin
        rodas_n   = (state_n == AVANCO) || (state_n == GIRO);
        sentido_n = (state_n == AVANCO);
        garra_n   = (state_n == RECOLHE);
        busy_n    = (state_n == AVANCO) || (state_n == GIRO) || (state_n == RECOLHE);
        done_n    = (state_n == FIM);
`ifdef ROBO_ATUADOR_RAMPA_EN
        if (RAMPA_GAP_EN && state_n == AVANCO && cnt_n == RAMPA_GAP) rodas_n = 1'b0;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= 8'd0;
            io.motor_esq   <= 1'b0;
            io.motor_dir   <= 1'b0;
            io.sentido_esq <= 1'b0;
            io.garra       <= 1'b0;
            io.busy        <= 1'b0;
            io.done        <= 1'b0;
            io.conflito    <= 1'b0;
            io.perdidos    <= 8'd0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            io.motor_esq   <= rodas_n;
            io.motor_dir   <= rodas_n;
            io.sentido_esq <= sentido_n;
            io.garra       <= garra_n;
            io.busy        <= busy_n;
            io.done        <= done_n;
            io.conflito    <= conflito_n;
            io.perdidos    <= perdidos_n;
        end
    end

endmodule

// File: doc/robo_atuador.md
# robo_atuador

Actuator sequencer placed directly downstream of the robot navigation FSM. Converts its one-cycle command strobes (avancar, girar, recolher_entulho) into timed wheel-motor and claw drive windows. Reports busy/done to the rest of the system and flags commands lost or conflicting. Sits between the navigation FSM and the motor/claw power drivers.

## Interface
- T_AVANCO, 8: active cycles per forward command (1..255)
- T_GIRO, 4: active cycles per turn command (1..255)
- T_ENTULHO, 6: active cycles per debris-collect command (1..255)
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  reset, asynchronous, active-high; clock clock
- avancar  in  1  forward command strobe, one cycle
- girar  in  1  turn-left command strobe, one cycle
- recolher_entulho  in  1  collect command strobe, one cycle
- motor_esq  out  1  left wheel enable
- motor_dir  out  1  right wheel enable
- sentido_esq  out  1  left wheel direction, 1 = forward
- garra  out  1  claw/collector enable
- busy  out  1  command in execution
- done  out  1  one-cycle completion pulse
- conflito  out  1  sticky: more than one strobe seen in the same cycle
- perdidos  out  8  saturating count of strobes dropped while busy

## Operation
- States: IDLE, AVANCO, GIRO, RECOLHE, FIM. 8-bit down-counter cnt.
- IDLE/FIM: any strobe accepted; priority recolher_entulho > girar > avancar. Load cnt = T_x − 1, go to matching state.
- Two or more strobes in an accepting cycle: highest priority executed, conflito set to 1 until reset.
- AVANCO: motor_esq=motor_dir=1, sentido_esq=1.
- GIRO: motor_esq=motor_dir=1, sentido_esq=0 (left wheel reverse, right forward; right wheel always forward).
- RECOLHE: garra=1, wheels off.
- Active state: cnt==0 -> FIM, else cnt−1. Strobes in active states dropped; perdidos += 1 per cycle with ≥1 strobe, saturates at 255.
- FIM: done=1, busy=0, drive outputs 0; no strobe -> IDLE.
- Outputs are registered (functions of state), all 0 in IDLE.
- busy = 1 in AVANCO, GIRO, RECOLHE only.

## Timing
- Reset (async, any time, mid-command included): state IDLE, cnt=0, all outputs 0, conflito=0, perdidos=0. Execution aborts immediately, no done.
- Strobe sampled at edge k -> drive outputs and busy high from k+1 for exactly T_x cycles.
- done high for the single cycle after the last active cycle; busy low that cycle.
- Back-to-back: strobe during the done cycle accepted; next window begins the following cycle. Max throughput one command per T_x+1 cycles.
- Strobe held high multiple cycles: first cycle accepted, remaining cycles counted as dropped.
- T_x=1: one active cycle, then done.

## Configuration
- ROBO_ATUADOR_RAMPA_EN defined: soft start in AVANCO only — during the first 2 active cycles (or all, if T_AVANCO<2) motor_esq/motor_dir pulse at 50%: 1 on the first active cycle, 0 on the second. sentido_esq, busy, timing and done unchanged.
- Undefined: wheels held constantly at 1 for the full AVANCO window. GIRO/RECOLHE never affected.

## Test plan
- Reset, then avancar pulse at cycle 5 -> motor_esq=motor_dir=sentido_esq=1 and busy=1 cycles 6–13, done=1 at 14, IDLE at 15 (default params, macro off).
- girar at cycle 2 -> motor_esq=motor_dir=1, sentido_esq=0 for cycles 3–6; done at 7; recolher_entulho in cycle 7 -> garra=1 cycles 8–13, done at 14.
- avancar+girar+recolher_entulho in the same cycle -> RECOLHE executed (garra 6 cycles), conflito=1, held until reset.
- During AVANCO, 3 separate strobe cycles -> perdidos=3, current window length unchanged; 300 dropped-strobe cycles -> perdidos=255.
- Reset asserted in 4th active cycle of AVANCO -> all outputs 0 same cycle, no done pulse, perdidos/conflito cleared.
- With ROBO_ATUADOR_RAMPA_EN, avancar -> wheel enables 1,0,1,1,1,1,1,1 over 8 active cycles; busy constant 1, done at cycle 9 after acceptance.
